// File: rtl/local_packet_injector.sv
// Phoenix LOCAL-port injector: a first-word-fall-through payload FIFO fed by the core,
// drained as header / size / payload flits under the router's credit flow control.
module local_packet_injector #(
    parameter int TAM_FLIT = 16,
    parameter int DEPTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [TAM_FLIT-1:0]     wr_data,
    output logic                    fifo_full,
    output logic [$clog2(DEPTH):0]  fifo_count,
    input  logic                    send_req,
    input  logic [TAM_FLIT-1:0]     send_target,
    input  logic [TAM_FLIT-1:0]     send_len,
    output logic                    send_ack,
    output logic                    send_err,
    output logic                    busy,
    output logic                    done,
    output logic                    tx,
    output logic [TAM_FLIT-1:0]     data_out,
    input  logic                    credit_i,
    output logic                    clock_tx
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = (TAM_FLIT > AW + 1) ? TAM_FLIT : AW + 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t              state, next_state;
    logic [TAM_FLIT-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic [TAM_FLIT-1:0] target_q, len_q, remaining;
    logic                push, pop, xfer, accept, reject, finish, len_fits;

    assign clock_tx   = clock;
    assign fifo_count = count;
    assign fifo_full  = (count == FULL_COUNT);
    assign push       = wr_en && !fifo_full;
    assign len_fits   = (CW'(send_len) <= CW'(count));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        finish     = 1'b0;
        pop        = 1'b0;
        tx         = 1'b0;
        busy       = 1'b0;
        data_out   = '0;
        xfer       = (state != IDLE) && credit_i;
        case (state)
            IDLE: begin
                if (send_req) begin
                    if (len_fits) begin
                        accept     = 1'b1;
                        next_state = HEADER;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            HEADER: begin
                tx       = 1'b1;
                busy     = 1'b1;
                data_out = target_q;
                if (xfer) next_state = SIZE;
            end
            SIZE: begin
                tx       = 1'b1;
                busy     = 1'b1;
                data_out = len_q;
                if (xfer) begin
                    if (len_q != '0) begin
                        next_state = PAYLOAD;
                    end else begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                tx       = 1'b1;
                busy     = 1'b1;
                data_out = mem[rd_ptr];
                if (xfer) begin
                    pop = 1'b1;
                    if (remaining == TAM_FLIT'(1)) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count define its valid contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            target_q  <= '0;
            len_q     <= '0;
            remaining <= '0;
            send_ack  <= 1'b0;
            send_err  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Packet length is frozen at acceptance; later core writes never extend it.
            if (accept) begin
                target_q  <= send_target;
                len_q     <= send_len;
                remaining <= send_len;
            end else if (pop) begin
                remaining <= remaining - 1'b1;
            end
            send_ack <= accept;
            send_err <= reject;
            done     <= finish;
        end
    end

endmodule
